// File: rtl/apb_pkg.sv
// ============================================================================
// Module : apb_pkg
// Brief  : Shared FSM state encoding and width helpers for apb_arb_master.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

    localparam int c_ST_W = 2;

    typedef enum logic [c_ST_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Slave-select field width; a single slave still needs a 1-bit field.
    function automatic int sel_bits(input int nslv);
        return (nslv > 1) ? $clog2(nslv) : 1;
    endfunction

    function automatic int strb_width(input int dw);
        return dw / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-input round-robin arbiter; pointer holder wins when valid.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_valid,
    input  logic       i_update,
    output logic [1:0] o_grant
);

    logic r_ptr;

    always_comb begin
        o_grant = 2'b00;
        if (r_ptr == 1'b0) begin
            if (i_valid[0])      o_grant = 2'b01;
            else if (i_valid[1]) o_grant = 2'b10;
        end else begin
            if (i_valid[1])      o_grant = 2'b10;
            else if (i_valid[0]) o_grant = 2'b01;
        end
    end

    // Priority passes to the requester that was not just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_update && (|o_grant)) begin
            r_ptr <= o_grant[0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_arb_master.sv
// ============================================================================
// Module : apb_arb_master
// Brief  : Two-requester round-robin APB master driving NSLV slaves.
//          Optional ACCESS-phase abort enabled by macro APB_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_arb_master
    import apb_pkg::*;
#(
    parameter int ADDWIDTH  = 8,
    parameter int DATAWIDTH = 32,
    parameter int NSLV      = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic                                   PCLK,
    input  logic                                   PRESET,
    input  logic [1:0]                             req_valid,
    input  logic [1:0]                             req_write,
    input  logic [2*ADDWIDTH-1:0]                  req_addr,
    input  logic [2*DATAWIDTH-1:0]                 req_wdata,
    input  logic [2*strb_width(DATAWIDTH)-1:0]     req_strb,
    output logic [1:0]                             req_ready,
    output logic [1:0]                             resp_valid,
    output logic [DATAWIDTH-1:0]                   resp_rdata,
    output logic                                   resp_err,
    output logic [NSLV-1:0]                        PSEL,
    output logic                                   PENABLE,
    output logic                                   PWRITE,
    output logic [ADDWIDTH-sel_bits(NSLV)-1:0]     PADDR,
    output logic [DATAWIDTH-1:0]                   PWDATA,
    output logic [strb_width(DATAWIDTH)-1:0]       PSTRB,
    input  logic [NSLV-1:0]                        PREADY,
    input  logic [NSLV*DATAWIDTH-1:0]              PRDATA
);

    localparam int c_SELBITS = sel_bits(NSLV);
    localparam int c_STRBW   = strb_width(DATAWIDTH);
    localparam int c_PAW     = ADDWIDTH - c_SELBITS;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_gidx;
    logic [c_SELBITS-1:0]   r_sel;
    logic [1:0]             w_grant;
    logic                   w_gidx;
    logic [ADDWIDTH-1:0]    w_addr;
    logic [DATAWIDTH-1:0]   w_wdata;
    logic [c_STRBW-1:0]     w_strb;
    logic                   w_write;
    logic                   w_pready_sel;
    logic [DATAWIDTH-1:0]   w_prdata_sel;
    logic [NSLV-1:0]        w_sel_onehot;
    logic                   w_accept;
    logic                   w_done;
    logic                   w_abort;
    logic                   w_timeout;

    rr_arb2 u_arb (
        .clk      (PCLK),
        .rst      (PRESET),
        .i_valid  (req_valid),
        .i_update (w_accept),
        .o_grant  (w_grant)
    );

    assign w_gidx  = w_grant[1];
    assign w_addr  = w_gidx ? req_addr[2*ADDWIDTH-1:ADDWIDTH]     : req_addr[ADDWIDTH-1:0];
    assign w_wdata = w_gidx ? req_wdata[2*DATAWIDTH-1:DATAWIDTH]  : req_wdata[DATAWIDTH-1:0];
    assign w_strb  = w_gidx ? req_strb[2*c_STRBW-1:c_STRBW]       : req_strb[c_STRBW-1:0];
    assign w_write = w_gidx ? req_write[1]                        : req_write[0];

    assign w_sel_onehot = {{(NSLV-1){1'b0}}, 1'b1} << r_sel;

    always_comb begin
        w_pready_sel = 1'b0;
        w_prdata_sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (r_sel == i[c_SELBITS-1:0]) begin
                w_pready_sel = PREADY[i];
                w_prdata_sel = PRDATA[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    logic [7:0] r_wait_cnt;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_wait_cnt <= 8'd0;
        end else if ((r_state == ST_ACCESS) && !PENABLE) begin
            r_wait_cnt <= 8'd0;
        end else if ((r_state == ST_ACCESS) && PENABLE && !w_pready_sel) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    assign w_timeout = (r_wait_cnt == 8'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ST_ACCESS spans both the APB setup phase (PENABLE low) and access phase.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PENABLE) begin
                    if (w_pready_sel) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (w_timeout) begin
                        w_abort     = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_gidx     <= 1'b0;
            r_sel      <= '0;
            req_ready  <= 2'b00;
            resp_valid <= 2'b00;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            PSEL       <= '0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            PSTRB      <= '0;
        end else begin
            req_ready  <= 2'b00;
            resp_valid <= 2'b00;
            resp_err   <= 1'b0;
            if (w_accept) begin
                req_ready <= w_grant;
                r_gidx    <= w_gidx;
                r_sel     <= w_addr[ADDWIDTH-1 -: c_SELBITS];
                PADDR     <= w_addr[c_PAW-1:0];
                PWRITE    <= w_write;
                PWDATA    <= w_wdata;
                PSTRB     <= w_write ? w_strb : '0;
            end
            if (r_state == ST_SETUP) begin
                PSEL <= w_sel_onehot;
            end
            if ((r_state == ST_ACCESS) && !PENABLE) begin
                PENABLE <= 1'b1;
            end
            if (w_done || w_abort) begin
                PSEL               <= '0;
                PENABLE            <= 1'b0;
                resp_valid[r_gidx] <= 1'b1;
                resp_err           <= w_abort;
                resp_rdata         <= (w_done && !PWRITE) ? w_prdata_sel : '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_apb_arb_master.sv
// ============================================================================
// Module : tb_apb_arb_master
// Brief  : Directed self-checking bench with two byte-strobed APB memory slaves.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_arb_master;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [1:0]  req_valid, req_write;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_strb;
    logic [1:0]  req_ready, resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  PSEL;
    logic        PENABLE, PWRITE;
    logic [6:0]  PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [1:0]  PREADY;
    logic [63:0] PRDATA;

    int n_cmp = 0;
    int n_err = 0;

    apb_arb_master dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    // Slave models: slave 0 zero-wait, slave 1 programmable waits or stuck.
    logic [31:0] mem0 [128];
    logic [31:0] mem1 [128];
    logic        mem_clr, bd_we, s1_stuck, mon_clr;
    logic [6:0]  bd_addr;
    logic [31:0] bd_data;
    int          s1_waits, s1_cnt;
    logic [3:0]  pstrb_acc;

    assign PREADY[0] = 1'b1;
    assign PREADY[1] = !s1_stuck && (s1_cnt >= s1_waits);
    assign PRDATA    = {mem1[PADDR], mem0[PADDR]};

    always @(posedge PCLK) begin
        if (!(PSEL[1] && PENABLE)) s1_cnt <= 0;
        else if (!PREADY[1])       s1_cnt <= s1_cnt + 1;
        if (mon_clr)   pstrb_acc <= 4'h0;
        else if (|PSEL) pstrb_acc <= pstrb_acc | PSTRB;
    end

    always @(posedge PCLK) begin
        if (mem_clr) begin
            for (int i = 0; i < 128; i++) begin
                mem0[i] <= 32'h0;
                mem1[i] <= 32'h0;
            end
        end else begin
            if (bd_we) mem1[bd_addr] <= bd_data;
            for (int b = 0; b < 4; b++) begin
                if (PSEL[0] && PENABLE && PREADY[0] && PWRITE && PSTRB[b])
                    mem0[PADDR][8*b +: 8] <= PWDATA[8*b +: 8];
                if (PSEL[1] && PENABLE && PREADY[1] && PWRITE && PSTRB[b])
                    mem1[PADDR][8*b +: 8] <= PWDATA[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_req(input int r, input logic w, input logic [7:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req_write[r]        = w;
        req_addr[r*8 +: 8]  = a;
        req_wdata[r*32 +: 32] = d;
        req_strb[r*4 +: 4]  = s;
        req_valid[r]        = 1'b1;
    endtask

    task automatic wait_ready(input int r, output logic ok);
        int n = 0;
        while (!req_ready[r] && n < 50) begin
            tick();
            n++;
        end
        req_valid[r] = 1'b0;
        ok = req_ready[r];
    endtask

    task automatic xfer(input int r, input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic er,
                        output logic got);
        logic ok;
        int   n = 0;
        rd  = '0;
        er  = 1'b0;
        got = 1'b0;
        set_req(r, w, a, d, s);
        wait_ready(r, ok);
        if (ok) begin
            while (!resp_valid[r] && n < 50) begin
                tick();
                n++;
            end
            if (resp_valid[r]) begin
                got = 1'b1;
                rd  = resp_rdata;
                er  = resp_err;
            end
        end
        tick();
    endtask

    task automatic do_reset();
        PRESET = 1'b1;
        tick();
        tick();
        PRESET = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er, got, ok, dbl, stable_bad, any_resp;
        logic [3:0]  order;
        int          ng, acc;

        PRESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        req_strb = '0; mem_clr = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        s1_stuck = 1'b0; s1_waits = 0; mon_clr = 1'b1;
        tick(); tick(); tick();
        mem_clr = 1'b0; mon_clr = 1'b0;
        check("rst_psel", PSEL, 2'b00);
        check("rst_penable", PENABLE, 1'b0);
        check("rst_ready", req_ready, 2'b00);
        check("rst_resp", resp_valid, 2'b00);
        check("rst_rdata_paddr_pstrb", {resp_rdata, PADDR, PSTRB}, 43'h0);
        PRESET = 1'b0;
        bd_we = 1'b1; bd_addr = 7'h05; bd_data = 32'h12345678;
        tick();
        bd_we = 1'b0;

        // Req0 write to slave0, zero wait, cycle-accurate timing.
        set_req(0, 1'b1, 8'h05, 32'hDEADBEEF, 4'hF);
        tick();
        req_valid[0] = 1'b0;
        check("t1_ready", req_ready, 2'b01);
        check("t1_psel_pre", PSEL, 2'b00);
        tick();
        check("t1_setup", {PSEL, PENABLE, PWRITE, PADDR, PSTRB}, {2'b01, 1'b0, 1'b1, 7'h05, 4'hF});
        check("t1_pwdata", PWDATA, 32'hDEADBEEF);
        tick();
        check("t1_access", {PSEL, PENABLE, resp_valid}, {2'b01, 1'b1, 2'b00});
        tick();
        check("t1_resp", {resp_valid, resp_err, PSEL, PENABLE}, {2'b01, 1'b0, 2'b00, 1'b0});
        check("t1_mem", mem0[5], 32'hDEADBEEF);
        tick();

        // Req1 read from slave1 with two wait states.
        s1_waits = 2;
        set_req(1, 1'b0, 8'h85, 32'h0, 4'hF);
        wait_ready(1, ok);
        check("t2_ready", req_ready, 2'b10);
        tick();
        check("t2_setup", {PSEL, PENABLE, PWRITE, PADDR, PSTRB}, {2'b10, 1'b0, 1'b0, 7'h05, 4'h0});
        acc = 0; stable_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (resp_valid != 2'b00) break;
            if (PENABLE && PSEL == 2'b10 && PADDR == 7'h05 && !PWRITE) acc++;
            else stable_bad = 1'b1;
        end
        check("t2_access_cycles", acc, 3);
        check("t2_stable", stable_bad, 1'b0);
        check("t2_resp", {resp_valid, resp_err}, {2'b10, 1'b0});
        check("t2_rdata", resp_rdata, 32'h12345678);
        tick();
        s1_waits = 0;

        // Both requesters held valid from reset: strict alternation.
        do_reset();
        set_req(0, 1'b1, 8'h10, 32'h11111111, 4'hF);
        set_req(1, 1'b1, 8'h11, 32'h22222222, 4'hF);
        ng = 0; dbl = 1'b0; order = 4'h0;
        for (int i = 0; i < 60 && ng < 4; i++) begin
            tick();
            if (req_ready == 2'b11) dbl = 1'b1;
            if (req_ready != 2'b00) begin
                order[ng] = req_ready[1];
                ng++;
            end
            if (ng == 4) req_valid = 2'b00;
        end
        req_valid = 2'b00;
        for (int i = 0; i < 6; i++) tick();
        check("t3_grants", ng, 4);
        check("t3_order", order, 4'b1010);
        check("t3_no_double", dbl, 1'b0);
        check("t3_mem", {mem0[16], mem0[17]}, {32'h11111111, 32'h22222222});

        // Partial-strobe write then read back; PSTRB must be 0 on the read.
        mon_clr = 1'b1; tick(); mon_clr = 1'b0;
        xfer(0, 1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, rd, er, got);
        check("t4_wr_pstrb", pstrb_acc, 4'b0101);
        mon_clr = 1'b1; tick(); mon_clr = 1'b0;
        xfer(1, 1'b0, 8'h20, 32'hFFFFFFFF, 4'hF, rd, er, got);
        check("t4_rd_got", got, 1'b1);
        check("t4_rd_data", rd, 32'h00BB00DD);
        check("t4_rd_pstrb", pstrb_acc, 4'h0);

        // Reset pulsed during ACCESS of a slave1 read.
        s1_waits = 3;
        set_req(1, 1'b0, 8'h85, 32'h0, 4'hF);
        wait_ready(1, ok);
        tick();
        tick();
        check("t5_in_access", {PSEL, PENABLE}, {2'b10, 1'b1});
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        check("t5_after_rst", {PSEL, PENABLE, resp_valid}, {2'b00, 1'b0, 2'b00});
        any_resp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (resp_valid != 2'b00) any_resp = 1'b1;
        end
        check("t5_no_resp", any_resp, 1'b0);
        xfer(0, 1'b0, 8'h05, 32'h0, 4'hF, rd, er, got);
        check("t5_next_ok", {got, er}, {1'b1, 1'b0});
        check("t5_next_data", rd, 32'hDEADBEEF);
        s1_waits = 0;

        // Slave1 PREADY stuck low.
        s1_stuck = 1'b1;
        set_req(1, 1'b0, 8'h85, 32'h0, 4'hF);
        wait_ready(1, ok);
        acc = 0; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (resp_valid[1]) begin
                got = 1'b1;
                break;
            end
            if (PENABLE) acc++;
        end
`ifdef APB_TIMEOUT_EN
        check("t6_resp", got, 1'b1);
        check("t6_err", resp_err, 1'b1);
        check("t6_rdata", resp_rdata, 32'h0);
        check("t6_access_cycles", acc, 16);
`else
        check("t6_no_resp", got, 1'b0);
        check("t6_psel_held", {PSEL, PENABLE}, {2'b10, 1'b1});
`endif
        s1_stuck = 1'b0;
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
